logic_unit_arbiter: RTL
=======================

# logic_unit_arbiter

Shares one combinational RV32 logical unit (AND/OR/XOR and ANDI/ORI/XORI) between two issue requesters. A round-robin arbiter grants one request per cycle, and the block registers the result in a single-entry output stage with a valid/ready handshake. It sits between the issue ports and writeback. It also flags any request whose opcode/func3 pair is not a logical operation.

## Interface
- `XLEN`, default 32: operand and result width.
- `TAG_W`, default 4: width of the opaque request tag, returned unchanged with the result.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid[1:0]`  in  2: per-requester request valid.
- `req_ready[1:0]`  out  2: per-requester grant/accept.
- `req_a[i]`, `req_b[i]`  in  XLEN each: rs1 operand, and rs2 or the sign-extended immediate.
- `req_opcode[i]`  in  7: instruction[6:0].
- `req_func3[i]`  in  3: instruction[14:12].
- `req_tag[i]`  in  TAG_W: opaque ID.
- `out_valid`  out  1: result register holds a result.
- `out_ready`  in  1: consumer accepts the result.
- `out_y`  out  XLEN: logical result.
- `out_src`  out  1: index of the requester that produced the result.
- `out_tag`  out  TAG_W: tag of the accepted request.
- `out_err`  out  1: the request was not a legal logical op; `out_y` is 0.

## Operation
- Legal op:
  - opcode is 0110011 (R) or 0010011 (I);
  - func3 is 100 (XOR), 110 (OR) or 111 (AND);
  - result is A^B, A|B or A&B respectively.
- Any other opcode/func3 is illegal: `y = 0` and `err = 1`. It is still accepted and returned, never dropped.
- Capacity rule: `can_accept = !out_valid || out_ready`.
- Arbitration: `rr_ptr` names the preferred requester.
  - If both requesters are valid and `can_accept`, grant `rr_ptr`.
  - If only one is valid, grant that one.
  - `req_ready[i]` is 1 only for the granted requester; at most one bit is high.
  - `req_ready` may depend on `req_valid`. Requesters must not make valid depend on ready.
- Pointer update: on every grant, `rr_ptr <= ~granted_index`. With no grant, the pointer holds.
- Output register states:
  - EMPTY → FULL on a grant.
  - FULL → FULL on a grant with `out_ready` high (back-to-back).
  - FULL → EMPTY on `out_ready` with no grant.
  - FULL holds, with all `out_*` stable, while `out_ready` is low.
- Requester obligations: once `req_valid[i]` is raised, hold it and its operands until `req_ready[i]` is seen.

## Timing
- Reset values: `out_valid` 0, `out_y` 0, `out_src` 0, `out_tag` 0, `out_err` 0, `rr_ptr` 0 (requester 0 preferred first).
- Latency: a request accepted at edge N appears with `out_valid = 1` from N+1.
- Throughput: one result per cycle while `out_ready` is high.
- Backpressure: when `out_valid = 1` and `out_ready = 0`, both `req_ready` bits are 0 in that same cycle.
- Same cycle drain and accept: the register loads the new result and `out_valid` stays 1. No bubble, no duplicate.
- Fairness: with both requesters continuously valid, grants strictly alternate; neither waits more than one grant.
- Reset mid-operation: the held result is discarded, `out_valid` drops to 0 immediately (asynchronously), and `rr_ptr` returns to 0.
- No request is accepted in the first edge after reset deassertion unless `req_valid` is presented then.

## Structure
- Shared package `alu_pkg`:
  - `OPCODE_R = 7'b0110011` and `OPCODE_I = 7'b0010011`;
  - func3 constants `F3_XOR`, `F3_OR` and `F3_AND`;
  - a `logic_req_t` struct carrying a, b, opcode, func3 and tag.
- One sub-module, `logic_core`: a purely combinational function of (a, b, opcode, func3) producing (y, err).
- Arbiter, pointer and output register live in the top module.

## Test plan
- Single request, R-AND: requester 0, A=AAAAFFFF, B=0F0F0F0F, opcode 0110011, func3 111, tag 3.
  - Next cycle: `out_valid=1`, `out_y=0A0A0F0F`, `out_src=0`, `out_tag=3`, `out_err=0`.
- I-type ops from requester 1: A=12345678, B=000000FF.
  - ORI → 123456FF.
  - XORI → 12345687.
  - ANDI → 00000078.
  - `out_src=1` on all three.
- Contention: both requesters valid every cycle for 6 cycles, `out_ready=1`.
  - Grant order 0,1,0,1,0,1.
  - Six results on consecutive cycles.
- Backpressure: hold `out_ready=0` for 3 cycles with `out_valid=1`.
  - `req_ready=00` throughout; `out_*` unchanged.
  - Raise `out_ready` with both requesters valid: the result drains and a new grant loads in the same cycle.
- Illegal ops:
  - opcode 0000011 with func3 111 → `out_y=0`, `out_err=1`, handshake completes normally.
  - func3 000 with opcode 0110011 → same response.
- Reset mid-flow: assert `rst` while `out_valid=1` and both requesters are valid.
  - `out_valid` goes to 0 without waiting for a clock edge.
  - After release, the first contended grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and request record for the RV32 logical-op unit.
// The record is sized for the default configuration.
package alu_pkg;

    localparam int unsigned REQ_XLEN  = 32;
    localparam int unsigned REQ_TAG_W = 4;

    localparam logic [6:0] OPCODE_R = 7'b0110011;
    localparam logic [6:0] OPCODE_I = 7'b0010011;

    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef struct packed {
        logic [REQ_XLEN-1:0]  a;
        logic [REQ_XLEN-1:0]  b;
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic [REQ_TAG_W-1:0] tag;
    } logic_req_t;

endpackage

// File: rtl/logic_core.sv
// Combinational RV32 AND/OR/XOR (R and I forms); anything else yields y=0, err=1.
module logic_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] y,
    output logic            err
);

    always_comb begin
        y   = '0;
        err = 1'b1;
        if (opcode == OPCODE_R || opcode == OPCODE_I) begin
            err = 1'b0;
            case (func3)
                F3_XOR:  y = a ^ b;
                F3_OR:   y = a | b;
                F3_AND:  y = a & b;
                default: err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared logical unit, with a
// single-entry valid/ready result register.
module logic_unit_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = REQ_XLEN,
    parameter int unsigned TAG_W = REQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [XLEN-1:0]  req_a      [2],
    input  logic [XLEN-1:0]  req_b      [2],
    input  logic [6:0]       req_opcode [2],
    input  logic [2:0]       req_func3  [2],
    input  logic [TAG_W-1:0] req_tag    [2],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_y,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e          state;
    logic            rr_ptr;
    logic            can_accept;
    logic            gnt;
    logic            gnt_idx;
    logic [XLEN-1:0] core_y;
    logic            core_err;

    // req_ready is a pure function of valid, pointer and output-stage capacity.
    always_comb begin
        can_accept = (state == StEmpty) || out_ready;
        gnt        = can_accept && (req_valid != 2'b00);
        gnt_idx    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
        req_ready  = 2'b00;
        if (gnt) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    logic_core #(
        .XLEN (XLEN)
    ) u_core (
        .a      (req_a[gnt_idx]),
        .b      (req_b[gnt_idx]),
        .opcode (req_opcode[gnt_idx]),
        .func3  (req_func3[gnt_idx]),
        .y      (core_y),
        .err    (core_err)
    );

    assign out_valid = (state == StFull);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StEmpty;
            rr_ptr  <= 1'b0;
            out_y   <= '0;
            out_src <= 1'b0;
            out_tag <= '0;
            out_err <= 1'b0;
        end else begin
            if (gnt) begin
                state   <= StFull;
                rr_ptr  <= ~gnt_idx;
                out_y   <= core_y;
                out_src <= gnt_idx;
                out_tag <= req_tag[gnt_idx];
                out_err <= core_err;
            end else if (out_ready) begin
                state <= StEmpty;
            end
        end
    end

endmodule
